// File: rtl/uart_rx_param.sv
// uart_rx_param: 16x oversampled UART receiver with valid/ready output.
// Define UART_RX_FIFO_EN for a 4-entry output FIFO.
module uart_rx_param #(
  parameter int CLK_FREQ  = 125000000,
  parameter int BAUD      = 4800,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int LED_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic [LED_W-1:0]     LED,
  output logic                 busy
);

  localparam int DIV = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_DONE,
    S_BRK
  } state_t;

  state_t state, state_n;

  logic                 rx_m, rx_s, rx_d;
  logic                 fall, tick, mid, maj;
  logic                 done, accept;
  logic [DW-1:0]        div_cnt;
  logic [3:0]           bt, bit_n;
  logic                 s7, s8;
  logic [DATA_BITS-1:0] sh;
  logic                 par_bad, stop_bad;

  assign fall = rx_d & ~rx_s;
  assign tick = (state != S_IDLE) && (div_cnt == DW'(DIV - 1));
  assign mid  = tick && (bt == 4'd9);
  assign maj  = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // two-flop synchroniser plus one flop of history for edge detect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // next state: every bit decision is taken on the tick-9 vote
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (fall) state_n = S_START;
      S_START: if (mid) state_n = maj ? S_IDLE : S_DATA;
      S_DATA:
        if (mid && bit_n == 4'(DATA_BITS - 1))
          state_n = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (mid) state_n = S_STOP;
      S_STOP:
        if (mid && bit_n == 4'(STOP_BITS - 1))
          state_n = S_DONE;
      S_DONE:  state_n = rx_s ? S_IDLE : S_BRK;
      S_BRK:   if (rx_s) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // tick divider, oversample counter, vote samples and frame capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt  <= '0;
      bt       <= '0;
      bit_n    <= '0;
      s7       <= 1'b1;
      s8       <= 1'b1;
      sh       <= '0;
      par_bad  <= 1'b0;
      stop_bad <= 1'b0;
    end else if (state == S_IDLE) begin
      div_cnt  <= '0;
      bt       <= '0;
      bit_n    <= '0;
      par_bad  <= 1'b0;
      stop_bad <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (tick) bt <= bt + 4'd1;
      if (tick && bt == 4'd7) s7 <= rx_s;
      if (tick && bt == 4'd8) s8 <= rx_s;
      if (mid) begin
        bit_n <= (state_n != state) ? 4'd0 : bit_n + 4'd1;
        if (state == S_DATA)
          sh <= {maj, sh[DATA_BITS-1:1]};
        if (state == S_PAR)
          par_bad <= (PARITY == 1) ? ~(^sh ^ maj) : (^sh ^ maj);
        if (state == S_STOP)
          stop_bad <= stop_bad | ~maj;
      end
    end
  end

`ifdef UART_RX_FIFO_EN
  logic [DATA_BITS-1:0] mem [4];
  logic [1:0]           wr_ptr, rd_ptr;
  logic [2:0]           count;
  logic                 pop;

  assign pop       = out_valid && out_ready;
  assign accept    = done && (count != 3'd4 || pop);
  assign out_valid = (count != 3'd0);
  assign out_data  = mem[rd_ptr];

  // 4-entry FIFO; push and pop may share a cycle even when full
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= sh;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'(accept) - 3'(pop);
    end
  end
`else
  assign accept = done && (!out_valid || out_ready);

  // single output register, held until the consumer takes it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      out_data  <= sh;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

  // error pulses and LED mirror of the last clean accepted word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      LED        <= '0;
    end else begin
      frame_err  <= done & stop_bad;
      parity_err <= done & par_bad;
      overrun    <= done & ~accept;
      if (accept && !stop_bad && !par_bad)
        LED <= sh[LED_W-1:0];
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed frames against a bounded-queue output model.
// A second instance runs with even parity.
module tb_uart_rx_param;

  localparam int DIV  = 10;
  localparam int BITC = 16 * DIV;
  localparam int LAT  = 4 + (16 * 9 + 10) * DIV;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx0 = 1'b1;
  logic       rxp = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] out_data, LED, p_data, p_led;
  logic       out_valid, frame_err, parity_err, overrun, busy;
  logic       p_valid, p_fe, p_pe, p_ov, p_busy;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  int hi_run = 0;
  int hi_len = 0;
  int cnt_fe = 0, cnt_pe = 0, cnt_ov = 0;
  int exp_fe = 0, exp_ovr = 0;
  int p_cnt = 0, p_pe_cnt = 0, p_fe_cnt = 0, p_ov_cnt = 0;
  int lat;
  logic [7:0] exp_q[$];
  logic [7:0] model_led = 8'h00;
  logic [7:0] last_data = 8'h00;
  logic [7:0] p_last = 8'h00;
  logic [7:0] pd = 8'h00;
  logic       pv = 1'b0;
  logic       phs = 1'b0;
  logic [7:0] a5 = 8'hA5;

  uart_rx_param #(
    .CLK_FREQ(100000000), .BAUD(625000), .PARITY(0)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx0),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(ready), .frame_err(frame_err),
    .parity_err(parity_err), .overrun(overrun),
    .LED(LED), .busy(busy)
  );

  uart_rx_param #(
    .CLK_FREQ(100000000), .BAUD(625000), .PARITY(2)
  ) dutp (
    .clk(clk), .reset(reset), .rx(rxp),
    .out_data(p_data), .out_valid(p_valid),
    .out_ready(1'b1), .frame_err(p_fe),
    .parity_err(p_pe), .overrun(p_ov),
    .LED(p_led), .busy(p_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // per-cycle compare against the model queue
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (out_valid && !pv) rise_cyc = cyc;
      if (out_valid) hi_run++;
      else begin
        if (pv) hi_len = hi_run;
        hi_run = 0;
      end
      if (pv && !phs && out_valid)
        chk("data_stable", out_data, pd);
      if (out_valid && ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h, expected none",
                   out_data);
        end else begin
          chk("word", out_data, exp_q.pop_front());
        end
        last_data = out_data;
      end
      if (frame_err) cnt_fe++;
      if (parity_err) cnt_pe++;
      if (overrun) cnt_ov++;
      if (p_valid) begin
        p_last = p_data;
        p_cnt++;
      end
      if (p_pe) p_pe_cnt++;
      if (p_fe) p_fe_cnt++;
      if (p_ov) p_ov_cnt++;
    end
    pv  = out_valid;
    pd  = out_data;
    phs = out_valid && ready;
  end

  task automatic drive(input bit sel, input logic v, input int n);
    if (sel) rxp = v;
    else     rx0 = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input bit sel, input logic [7:0] d,
                      input int par, input logic stp,
                      input int nstop);
    if (!sel) start_cyc = cyc;
    drive(sel, 1'b0, BITC);
    for (int i = 0; i < 8; i++) drive(sel, d[i], BITC);
    if (par >= 0) drive(sel, par[0], BITC);
    drive(sel, stp, BITC * nstop);
  endtask

  task automatic frame_a(input logic [7:0] d);
    if (exp_q.size() < CAP) begin
      exp_q.push_back(d);
      model_led = d;
    end else begin
      exp_ovr++;
    end
    send(1'b0, d, -1, 1'b1, 1);
    drive(1'b0, 1'b1, BITC);
    chk("frame_err_cnt", cnt_fe, exp_fe);
    chk("overrun_cnt", cnt_ov, exp_ovr);
    chk("parity_err_cnt", cnt_pe, 0);
    chk("led", LED, model_led);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #2 ready = v;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_led", LED, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", {frame_err, parity_err, overrun}, 0);
    reset = 1'b1;
    drive(1'b0, 1'b1, BITC);

    // clean 0xEB with consumer ready
    frame_a(8'hEB);
    chk("t1_data", last_data, 8'hEB);
    chk("t1_led", LED, 8'hEB);
    chk("t1_pulse_len", hi_len, 1);
    lat = rise_cyc - start_cyc;
    n_chk++;
    if (lat < LAT - 1 || lat > LAT + 1) begin
      n_fail++;
      $display("FAIL t1_latency: got %0d, expected %0d", lat, LAT);
    end

    // short low glitch on an idle line
    drive(1'b0, 1'b0, 38);
    chk("t2_busy_start", busy, 1);
    drive(1'b0, 1'b1, 2 * BITC);
    chk("t2_busy_idle", busy, 0);
    chk("t2_fe", cnt_fe, exp_fe);
    chk("t2_ov", cnt_ov, exp_ovr);
    chk("t2_q", exp_q.size(), 0);

    // 0x55 with stop held low into a break
    exp_q.push_back(8'h55);
    exp_fe++;
    send(1'b0, 8'h55, -1, 1'b0, 2);
    chk("t3_break_busy", busy, 1);
    chk("t3_fe", cnt_fe, exp_fe);
    drive(1'b0, 1'b1, BITC);
    chk("t3_idle", busy, 0);
    chk("t3_data", last_data, 8'h55);
    chk("t3_led", LED, 8'hEB);
    chk("t3_pe", cnt_pe, 0);

    // even parity: wrong bit then right bit
    send(1'b1, 8'h07, 0, 1'b1, 1);
    drive(1'b1, 1'b1, BITC);
    chk("t4a_cnt", p_cnt, 1);
    chk("t4a_data", p_last, 8'h07);
    chk("t4a_pe", p_pe_cnt, 1);
    chk("t4a_led", p_led, 8'h00);
    send(1'b1, 8'h07, 1, 1'b1, 1);
    drive(1'b1, 1'b1, BITC);
    chk("t4b_cnt", p_cnt, 2);
    chk("t4b_data", p_last, 8'h07);
    chk("t4b_pe", p_pe_cnt, 1);
    chk("t4b_led", p_led, 8'h07);
    chk("t4_fe", p_fe_cnt, 0);
    chk("t4_ov", p_ov_cnt, 0);
    chk("t4_busy", p_busy, 0);

    // consumer stalled: one more frame than storage holds
    set_ready(1'b0);
    for (int i = 0; i <= CAP; i++)
      frame_a(8'(8'h11 * (i + 1)));
    chk("t5_valid", out_valid, 1);
    chk("t5_data", out_data, 8'h11);
    chk("t5_ovr", cnt_ov, 1);
    set_ready(1'b1);
    repeat (10) @(negedge clk);
    chk("t5_drained", exp_q.size(), 0);
    chk("t5_empty", out_valid, 0);

    // reset in the middle of the data bits of 0xA5
    drive(1'b0, 1'b0, BITC);
    for (int i = 0; i < 4; i++) drive(1'b0, a5[i], BITC);
    drive(1'b0, a5[4], BITC / 2);
    reset = 1'b0;
    rx0 = 1'b1;
    model_led = 8'h00;
    repeat (2) @(negedge clk);
    chk("t6_valid", out_valid, 0);
    chk("t6_data", out_data, 0);
    chk("t6_led", LED, 0);
    chk("t6_busy", busy, 0);
    chk("t6_err", {frame_err, parity_err, overrun}, 0);
    reset = 1'b1;
    drive(1'b0, 1'b1, BITC);
    frame_a(8'h3C);
    chk("t6_data_after", last_data, 8'h3C);
    chk("t6_q", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
